// File: rtl/mips_cpu_lsu_if.sv
// rtl/mips_cpu_lsu_if.sv - core request/response and memory bus bundle for the LSU
interface mips_cpu_lsu_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        stall;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  // Core plus memory side: drives requests and memory responses.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_address, req_wdata,
    output mem_readdata, mem_waitrequest,
    input  req_ready, resp_valid, resp_rdata, resp_error, stall,
    input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
  );

  // The LSU itself.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_address, req_wdata,
    input  mem_readdata, mem_waitrequest,
    output req_ready, resp_valid, resp_rdata, resp_error, stall,
    output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
  );
endinterface

// File: rtl/mips_cpu_lsu.sv
// rtl/mips_cpu_lsu.sv - MIPS load/store unit: alignment, lane steering, extension, timeout
module mips_cpu_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset,
  mips_cpu_lsu_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [15:0] cnt_q;
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;

  logic        bad_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;

  // Classify the incoming request and steer store data onto byte lanes.
  always_comb begin
    bad_d   = 1'b0;
    be_d    = 4'b0000;
    wdata_d = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be_d    = 4'b0001 << bus.req_address[1:0];
        wdata_d = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        bad_d   = bus.req_address[0];
        be_d    = bus.req_address[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        bad_d = (bus.req_address[1:0] != 2'b00);
        be_d  = 4'b1111;
      end
      default: bad_d = 1'b1;
    endcase
  end

  // Pick the addressed lane(s) out of the read word and extend to 32 bits.
  always_comb begin
    case (off_q)
      2'd0:    byte_d = bus.mem_readdata[7:0];
      2'd1:    byte_d = bus.mem_readdata[15:8];
      2'd2:    byte_d = bus.mem_readdata[23:16];
      default: byte_d = bus.mem_readdata[31:24];
    endcase
    half_d = off_q[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];
    case (size_q)
      2'b00:   load_d = {{24{signed_q & byte_d[7]}}, byte_d};
      2'b01:   load_d = {{16{signed_q & half_d[15]}}, half_d};
      default: load_d = bus.mem_readdata;
    endcase
  end

  // Control FSM; every bus-facing output is a register so it stays stable during waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      off_q         <= 2'b00;
      cnt_q         <= 16'd0;
      mem_address_q <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      be_q          <= 4'b0000;
      wdata_q       <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      resp_error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            off_q    <= bus.req_address[1:0];
            if (bad_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else begin
              state_q       <= ACCESS;
              cnt_q         <= 16'd0;
              mem_address_q <= {bus.req_address[31:2], 2'b00};
              mem_read_q    <= ~bus.req_write;
              mem_write_q   <= bus.req_write;
              be_q          <= be_d;
              wdata_q       <= bus.req_write ? wdata_d : 32'd0;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_waitrequest && (cnt_q + 16'd1 != TMO)) begin
            cnt_q <= cnt_q + 16'd1;
          end else begin
            // Either the memory answered or the wait budget ran out.
            state_q       <= RESP;
            resp_valid_q  <= 1'b1;
            resp_error_q  <= bus.mem_waitrequest;
            resp_rdata_q  <= (!bus.mem_waitrequest && mem_read_q) ? load_d : 32'd0;
            mem_address_q <= 32'd0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            be_q          <= 4'b0000;
            wdata_q       <= 32'd0;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'd0;
          resp_error_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.stall          = (bus.req_valid && !reset && state_q == IDLE) || (state_q == ACCESS);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_byteenable = be_q;
  assign bus.mem_writedata  = wdata_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb/tb_mips_cpu_lsu.sv - directed self-checking bench for mips_cpu_lsu
module tb_mips_cpu_lsu;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mips_cpu_lsu_if bus();

  mips_cpu_lsu #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid   = 1'b1;
    bus.req_write   = wr;
    bus.req_size    = sz;
    bus.req_signed  = sg;
    bus.req_address = addr;
    bus.req_wdata   = wd;
  endtask

  task automatic drop_req();
    bus.req_valid   = 1'b0;
    bus.req_address = 32'hDEAD_BEEF;
    bus.req_size    = 2'b11;
    bus.req_wdata   = 32'h5555_5555;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_address = 32'h0;
    bus.req_wdata = 32'h0;
    bus.mem_readdata = 32'h0;
    bus.mem_waitrequest = 1'b0;
    step();
    step();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_addr", bus.mem_address, 32'd0);

    // Store byte at 0x1003, zero waits.
    issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB);
    #1;
    chk("sb_stall_n", {31'd0, bus.stall}, 32'd1);
    step();
    drop_req();
    chk("sb_write", {31'd0, bus.mem_write}, 32'd1);
    chk("sb_read", {31'd0, bus.mem_read}, 32'd0);
    chk("sb_addr", bus.mem_address, 32'h0000_1000);
    chk("sb_be", {28'd0, bus.mem_byteenable}, 32'h8);
    chk("sb_wdata", bus.mem_writedata, 32'hABAB_ABAB);
    chk("sb_resp_n1", {31'd0, bus.resp_valid}, 32'd0);
    step();
    chk("sb_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("sb_err", {31'd0, bus.resp_error}, 32'd0);
    chk("sb_rdata", bus.resp_rdata, 32'd0);
    chk("sb_ready_resp", {31'd0, bus.req_ready}, 32'd0);
    chk("sb_stall_resp", {31'd0, bus.stall}, 32'd0);
    chk("sb_strobe_off", {31'd0, bus.mem_write}, 32'd0);
    step();
    chk("sb_resp_end", {31'd0, bus.resp_valid}, 32'd0);
    chk("sb_ready_end", {31'd0, bus.req_ready}, 32'd1);

    // Signed load half at 0x2002 with three wait cycles.
    bus.mem_waitrequest = 1'b1;
    issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
    step();
    drop_req();
    chk("lh_read", {31'd0, bus.mem_read}, 32'd1);
    chk("lh_be", {28'd0, bus.mem_byteenable}, 32'hC);
    chk("lh_addr", bus.mem_address, 32'h0000_2000);
    step();
    step();
    chk("lh_hold_addr", bus.mem_address, 32'h0000_2000);
    chk("lh_hold_read", {31'd0, bus.mem_read}, 32'd1);
    chk("lh_stall_wait", {31'd0, bus.stall}, 32'd1);
    step();
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata = 32'h8001_1234;
    chk("lh_resp_early", {31'd0, bus.resp_valid}, 32'd0);
    step();
    chk("lh_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("lh_rdata", bus.resp_rdata, 32'hFFFF_8001);
    chk("lh_err", {31'd0, bus.resp_error}, 32'd0);
    step();

    // Unsigned then signed byte loads at 0x2001.
    bus.mem_readdata = 32'h0000_F000;
    issue(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0);
    step();
    drop_req();
    chk("lbu_be", {28'd0, bus.mem_byteenable}, 32'h2);
    step();
    chk("lbu_rdata", bus.resp_rdata, 32'h0000_00F0);
    step();
    issue(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0);
    step();
    drop_req();
    step();
    chk("lb_rdata", bus.resp_rdata, 32'hFFFF_FFF0);
    step();

    // Word load and half store.
    bus.mem_readdata = 32'h1234_5678;
    issue(1'b0, 2'b10, 1'b1, 32'h0000_2000, 32'h0);
    step();
    drop_req();
    chk("lw_be", {28'd0, bus.mem_byteenable}, 32'hF);
    step();
    chk("lw_rdata", bus.resp_rdata, 32'h1234_5678);
    step();
    issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
    step();
    drop_req();
    chk("sh_be", {28'd0, bus.mem_byteenable}, 32'hC);
    chk("sh_wdata", bus.mem_writedata, 32'hABCD_ABCD);
    step();
    step();

    // Misaligned word and illegal size go straight to an error response.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0);
    step();
    drop_req();
    chk("mis_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("mis_err", {31'd0, bus.resp_error}, 32'd1);
    chk("mis_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("mis_rdata", bus.resp_rdata, 32'd0);
    step();
    chk("mis_end", {31'd0, bus.resp_valid}, 32'd0);
    issue(1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'h0);
    step();
    drop_req();
    chk("ill_err", {31'd0, bus.resp_error}, 32'd1);
    chk("ill_strobe", {31'd0, bus.mem_write}, 32'd0);
    step();

    // Timeout after four wait cycles.
    bus.mem_waitrequest = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
    step();
    drop_req();
    chk("to_read1", {31'd0, bus.mem_read}, 32'd1);
    step();
    step();
    step();
    chk("to_read4", {31'd0, bus.mem_read}, 32'd1);
    chk("to_resp4", {31'd0, bus.resp_valid}, 32'd0);
    step();
    chk("to_read_off", {31'd0, bus.mem_read}, 32'd0);
    chk("to_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("to_err", {31'd0, bus.resp_error}, 32'd1);
    chk("to_rdata", bus.resp_rdata, 32'd0);
    step();
    chk("to_idle", {31'd0, bus.req_ready}, 32'd1);
    chk("to_err_clr", {31'd0, bus.resp_error}, 32'd0);

    // Reset during the second wait cycle of a load.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    step();
    drop_req();
    step();
    reset = 1'b1;
    step();
    chk("rs_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rs_resp", {31'd0, bus.resp_valid}, 32'd0);
    reset = 1'b0;
    bus.mem_waitrequest = 1'b0;
    step();
    chk("rs_resp2", {31'd0, bus.resp_valid}, 32'd0);
    step();
    chk("rs_resp3", {31'd0, bus.resp_valid}, 32'd0);
    chk("rs_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_cpu_lsu.md
MIPS_CPU_LSU -- requirements
Module: mips_cpu_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum consecutive mem_waitrequest cycles before an access is aborted; the legal range is 1..65535.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core requests a data access.
REQ-005 req_write  input  1  1=store, 0=load.
REQ-006 req_size  input  2  access size: 00=byte, 01=half, 10=word; 11 is illegal.
REQ-007 req_signed  input  1  sign-extend a load result (LB/LH); 0 selects zero-extend (LBU/LHU).
REQ-008 req_address  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 req_ready  output  1  the LSU can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle pulse marking completion.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 resp_error  output  1  qualifies resp_valid: misaligned, illegal size, or timeout.
REQ-014 stall  output  1  the core must hold its PC and register write.
REQ-015 mem_address  output  32  word-aligned address, low 2 bits = 0.
REQ-016 mem_read, mem_write  output  1 each  memory strobes.
REQ-017 mem_byteenable  output  4  byte lanes; bit k covers bits 8k+7:8k.
REQ-018 mem_writedata  output  32  lane-replicated store data.
REQ-019 mem_readdata  input  32  read data, valid in the cycle mem_waitrequest=0 with mem_read=1.
REQ-020 mem_waitrequest  input  1  memory is not ready; all mem_* outputs must be held stable while it is 1.

Function
REQ-021 The FSM SHALL have the states IDLE, ACCESS, RESP.
REQ-022 In IDLE, req_ready SHALL be 1 and all other outputs SHALL be 0.
REQ-023 Acceptance:
  - a request is accepted when req_valid=1 and req_ready=1;
  - all req_* fields SHALL be registered on acceptance;
  - later changes to req_* SHALL be ignored until the next acceptance.
REQ-024 Legal accepted request: the FSM SHALL go IDLE->ACCESS, and mem_read or mem_write SHALL be asserted from the next cycle.
REQ-025 Misaligned or illegal accepted request: the FSM SHALL go IDLE->RESP without any memory strobe, and set resp_error=1.
  - misaligned means size=half with addr[0]=1, or size=word with addr[1:0]!=00;
  - illegal means size=11.
REQ-026 Byte enables, where off = addr[1:0]:
  - byte: lane off only;
  - half: 0011 for off=0, 1100 for off=2;
  - word: 1111.
REQ-027 Store data replication:
  - byte: wdata[7:0] on all four lanes;
  - half: wdata[15:0] on both halves;
  - word: unchanged.
REQ-028 ACCESS SHALL hold while mem_waitrequest=1; when mem_waitrequest=0, the FSM SHALL go to RESP and capture the load lane data in that same cycle.
REQ-029 Load extraction:
  - byte: lane off;
  - half: bits 15:0 for off=0, bits 31:16 for off=2;
  - extension to 32 bits per req_signed;
  - word loads unmodified.
REQ-030 Timeout:
  - a 16-bit counter SHALL count consecutive waitrequest cycles in ACCESS;
  - when it reaches TIMEOUT, the strobes SHALL deassert and the FSM SHALL go to RESP with resp_error=1;
  - the counter SHALL clear on entering ACCESS.
REQ-031 RESP SHALL last exactly one cycle with resp_valid=1, then go to IDLE; req_ready SHALL be 0 in RESP.
REQ-032 stall SHALL equal (req_valid and IDLE) or ACCESS, i.e. it is high from the request cycle until the cycle before resp_valid.
REQ-033 Minimum latency: request accepted in cycle N, strobe in N+1 with waitrequest=0, resp_valid in N+2.
REQ-034 resp_rdata and resp_error SHALL be 0 whenever resp_valid=0.

Reset
REQ-035 While reset=1, the FSM SHALL be forced to IDLE, and all outputs except req_ready SHALL be 0 in the cycle after reset is sampled.
REQ-036 Reset asserted in ACCESS SHALL abort the access, drop the strobes the next cycle, and produce no resp_valid.
REQ-037 req_valid SHALL be ignored while reset=1.

Verification
REQ-038 Store byte: addr=0x1003, wdata=0x000000AB, zero wait states -> mem_address=0x1000, be=1000, writedata=0xABABABAB in N+1; resp_valid, error=0 in N+2.
REQ-039 Signed load half: addr=0x2002, mem_readdata=0x8001_1234, 3 wait cycles -> resp_rdata=0xFFFF8001, resp_valid 5 cycles after acceptance.
REQ-040 Unsigned load byte: addr=0x2001, readdata=0x0000F000 -> resp_rdata=0x000000F0.
REQ-041 Misaligned word at 0x3002 -> no mem_read/mem_write ever, resp_valid=1 and resp_error=1 in N+1.
REQ-042 TIMEOUT=4 with waitrequest held 1 -> strobe for 4 cycles, then resp_error=1 pulse and return to IDLE.
REQ-043 Reset asserted in the second wait cycle of a load -> strobes low in the next cycle, no resp_valid, req_ready=1 after reset releases.
